// File: rtl/voice_scheduler.sv
// ---------------------------------------------------------------------------
// voice_scheduler
//
// Polyphonic voice allocator for the oscillator bank. Note-on / note-off
// events arrive over a valid/ready handshake. Each event is resolved by
// scanning one voice per cycle, then committed in a single cycle. A note-on
// either retriggers a voice already holding the same note, takes the
// lowest-index free voice, or steals the oldest voice. A note-off releases
// the lowest-index gated voice holding that note.
//
// Ports
//   mclk            master clock, only clock of the block
//   rst             synchronous active-high reset
//   pblrc           sample-rate clock; each rising edge ages every voice
//   evt_valid       event present
//   evt_ready       event can be accepted (IDLE and not in reset)
//   evt_on          1 = note-on, 0 = note-off
//   evt_freq        note frequency word, also used as the note identity
//   evt_volume      note-on volume; 0 turns a note-on into a note-off
//   voice_frequency per-voice frequency words, voice i at [i*FREQ_RES_BITS +: FREQ_RES_BITS]
//   voice_volume    per-voice volume words, voice i at [i*VOLUME_BITS +: VOLUME_BITS]
//   voice_gate      per-voice gate, 1 = note held
//   voice_trigger   one-cycle pulse per voice when it is (re)started
//   steal           one-cycle pulse when a note-on took a gated voice
//   miss            one-cycle pulse when a note-off matched no gated voice
//   active_count    number of gated voices
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for an event, evt_ready high
//   SCAN   | examining voice idx, updating match / free / oldest candidates
//   COMMIT | applying the decision and pulsing trigger / steal / miss
// ---------------------------------------------------------------------------
module voice_scheduler #(
    parameter int NUM_VOICES    = 4,
    parameter int FREQ_RES_BITS = 8,
    parameter int VOLUME_BITS   = 8,
    parameter int AGE_BITS      = 8
) (
    input  logic                                mclk,
    input  logic                                rst,
    input  logic                                pblrc,
    input  logic                                evt_valid,
    output logic                                evt_ready,
    input  logic                                evt_on,
    input  logic [FREQ_RES_BITS-1:0]            evt_freq,
    input  logic [VOLUME_BITS-1:0]              evt_volume,
    output logic [NUM_VOICES*FREQ_RES_BITS-1:0] voice_frequency,
    output logic [NUM_VOICES*VOLUME_BITS-1:0]   voice_volume,
    output logic [NUM_VOICES-1:0]               voice_gate,
    output logic [NUM_VOICES-1:0]               voice_trigger,
    output logic                                steal,
    output logic                                miss,
    output logic [$clog2(NUM_VOICES+1)-1:0]     active_count
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [AGE_BITS-1:0] AGE_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]         idx;
    logic                     ev_on;
    logic [FREQ_RES_BITS-1:0] ev_freq;
    logic [VOLUME_BITS-1:0]   ev_vol;

    logic                     match_vld;
    logic [IDX_W-1:0]         match_idx;
    logic                     free_vld;
    logic [IDX_W-1:0]         free_idx;
    logic [IDX_W-1:0]         oldest_idx;

    logic [FREQ_RES_BITS-1:0] freq_r [NUM_VOICES];
    logic [VOLUME_BITS-1:0]   vol_r  [NUM_VOICES];
    logic [AGE_BITS-1:0]      age_r  [NUM_VOICES];

    logic                     pblrc_q;
    logic                     tick;
    logic                     accept;

    logic                     note_on;
    logic [IDX_W-1:0]         sel_idx;
    logic                     do_alloc;
    logic                     do_retrig;
    logic                     do_release;
    logic                     steal_nxt;
    logic                     miss_nxt;
    logic [NUM_VOICES-1:0]    trig_nxt;
    logic [NUM_VOICES-1:0]    gate_nxt;
    logic [CNT_W-1:0]         gate_cnt;

    assign tick   = pblrc & ~pblrc_q;
    assign accept = evt_valid & evt_ready;

    // ---------------- state register ----------------
    always_ff @(posedge mclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (idx == LAST_IDX) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- output / decision logic ----------------
    always_comb begin
        evt_ready  = (state == IDLE) && !rst;
        note_on    = ev_on && (ev_vol != '0);
        sel_idx    = '0;
        do_alloc   = 1'b0;
        do_retrig  = 1'b0;
        do_release = 1'b0;
        steal_nxt  = 1'b0;
        miss_nxt   = 1'b0;
        trig_nxt   = '0;
        gate_nxt   = voice_gate;

        if (state == COMMIT) begin
            if (note_on) begin
                if (match_vld) begin
                    sel_idx   = match_idx;
                    do_retrig = 1'b1;
                end else if (free_vld) begin
                    sel_idx  = free_idx;
                    do_alloc = 1'b1;
                end else begin
                    sel_idx   = oldest_idx;
                    do_alloc  = 1'b1;
                    steal_nxt = 1'b1;
                end
            end else begin
                if (match_vld) begin
                    sel_idx    = match_idx;
                    do_release = 1'b1;
                end else begin
                    miss_nxt = 1'b1;
                end
            end
        end

        if (do_alloc || do_retrig) trig_nxt[sel_idx] = 1'b1;
        if (do_alloc)              gate_nxt[sel_idx] = 1'b1;
        if (do_release)            gate_nxt[sel_idx] = 1'b0;
    end

    always_comb begin
        gate_cnt = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            gate_cnt = gate_cnt + CNT_W'(gate_nxt[i]);
        end
    end

    // ---------------- event latch and scan candidates ----------------
    // The oldest comparison reads the live age of the current candidate so
    // that both sides of the compare are taken on the same cycle.
    always_ff @(posedge mclk) begin
        if (rst) begin
            idx        <= '0;
            ev_on      <= 1'b0;
            ev_freq    <= '0;
            ev_vol     <= '0;
            match_vld  <= 1'b0;
            match_idx  <= '0;
            free_vld   <= 1'b0;
            free_idx   <= '0;
            oldest_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ev_on      <= evt_on;
                        ev_freq    <= evt_freq;
                        ev_vol     <= evt_volume;
                        idx        <= '0;
                        match_vld  <= 1'b0;
                        match_idx  <= '0;
                        free_vld   <= 1'b0;
                        free_idx   <= '0;
                        oldest_idx <= '0;
                    end
                end
                SCAN: begin
                    idx <= idx + IDX_W'(1);
                    if (!match_vld && voice_gate[idx] && (freq_r[idx] == ev_freq)) begin
                        match_vld <= 1'b1;
                        match_idx <= idx;
                    end
                    if (!free_vld && !voice_gate[idx]) begin
                        free_vld <= 1'b1;
                        free_idx <= idx;
                    end
                    if (age_r[idx] > age_r[oldest_idx]) begin
                        oldest_idx <= idx;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- voice state ----------------
    always_ff @(posedge mclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                freq_r[i] <= '0;
                vol_r[i]  <= '0;
                age_r[i]  <= '0;
            end
            pblrc_q       <= 1'b0;
            voice_gate    <= '0;
            voice_trigger <= '0;
            steal         <= 1'b0;
            miss          <= 1'b0;
            active_count  <= '0;
        end else begin
            pblrc_q       <= pblrc;
            voice_gate    <= gate_nxt;
            voice_trigger <= trig_nxt;
            steal         <= steal_nxt;
            miss          <= miss_nxt;
            active_count  <= gate_cnt;
            for (int i = 0; i < NUM_VOICES; i++) begin
                // a (re)started voice restarts at age 0 even on a tick cycle
                if ((do_alloc || do_retrig) && (sel_idx == IDX_W'(i))) begin
                    age_r[i] <= '0;
                end else if (tick && (age_r[i] != AGE_MAX)) begin
                    age_r[i] <= age_r[i] + AGE_BITS'(1);
                end
                if (do_alloc && (sel_idx == IDX_W'(i))) begin
                    freq_r[i] <= ev_freq;
                end
                if ((do_alloc || do_retrig) && (sel_idx == IDX_W'(i))) begin
                    vol_r[i] <= ev_vol;
                end
            end
        end
    end

    always_comb begin
        voice_frequency = '0;
        voice_volume    = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_frequency[i*FREQ_RES_BITS +: FREQ_RES_BITS] = freq_r[i];
            voice_volume[i*VOLUME_BITS +: VOLUME_BITS]         = vol_r[i];
        end
    end

endmodule
